// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store data-memory front-end.
package lsu_pkg;

   typedef enum logic [2:0] {
      LB  = 3'd0,
      LH  = 3'd1,
      LW  = 3'd2,
      LBU = 3'd4,
      LHU = 3'd5
   } lsu_f3_e;

   // Per-load bookkeeping carried from issue to read-data return
   typedef struct packed {
      logic [1:0] off;
      logic [2:0] f3;
   } lsu_meta_t;

   // Access size codes
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // Access size from funct3; unknown codes behave as word accesses
   function automatic logic [1:0] lsu_size(input logic [2:0] f3);
      logic [1:0] sz;
      case (f3)
         LB, LBU: sz = SZ_B;
         LH, LHU: sz = SZ_H;
         default: sz = SZ_W;
      endcase
      return sz;
   endfunction

   // Byte-lane mask for an access of the given size at an (already aligned) offset
   function automatic logic [3:0] lsu_mask(input logic [1:0] sz, input logic [1:0] off);
      logic [3:0] m;
      case (sz)
         SZ_B:    m = 4'b0001 << off;
         SZ_H:    m = 4'b0011 << off;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Store data replicated across every lane the access could land on
   function automatic logic [31:0] lsu_wdata(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] d;
      case (sz)
         SZ_B:    d = {4{wd[7:0]}};
         SZ_H:    d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

   // Misaligned or unsupported request (only used when trapping is built in)
   function automatic logic lsu_trap(input logic [2:0] f3, input logic [1:0] off);
      logic t;
      case (f3)
         3'd3, 3'd6, 3'd7: t = 1'b1;
         LH, LHU:          t = off[0];
         LW:               t = (off != 2'b00);
         default:          t = 1'b0;
      endcase
      return t;
   endfunction

   // Right-justify the addressed lanes of a RAM word and sign/zero extend
   function automatic logic [31:0] lsu_extend(input logic [31:0] rdata, input lsu_meta_t meta);
      logic [31:0] sh;
      logic [31:0] r;
      sh = rdata >> {meta.off, 3'b000};
      case (meta.f3)
         LB:      r = {{24{sh[7]}}, sh[7:0]};
         LH:      r = {{16{sh[15]}}, sh[15:0]};
         LBU:     r = {24'd0, sh[7:0]};
         LHU:     r = {16'd0, sh[15:0]};
         default: r = sh;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO is taken when a pop
// happens in the same cycle. Head word is read straight from storage.
module lsu_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rstf,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rdata,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wptr_r;
   logic [PTR_W-1:0] rptr_r;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_next_s;
   logic             full_s;
   logic             do_push_s;
   logic             do_pop_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] n;
      if (p == PTR_W'(DEPTH - 1)) begin
         n = {PTR_W{1'b0}};
      end else begin
         n = p + PTR_W'(1);
      end
      return n;
   endfunction

   assign empty     = (count_r == {CNT_W{1'b0}});
   assign full_s    = (count_r == CNT_W'(DEPTH));
   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full_s | do_pop_s);
   assign rdata     = mem_r[rptr_r];
   assign count     = count_r;

   // Occupancy after this cycle's push/pop
   always_comb begin
      count_next_s = count_r;
      case ({do_push_s, do_pop_s})
         2'b10:   count_next_s = count_r + CNT_W'(1);
         2'b01:   count_next_s = count_r - CNT_W'(1);
         default: count_next_s = count_r;
      endcase
   end

   // Storage and pointers; contents cleared so the head reads zero out of reset
   always_ff @(posedge clk) begin
      if (rstf) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         wptr_r  <= {PTR_W{1'b0}};
         rptr_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            mem_r[wptr_r] <= wdata;
            wptr_r        <= ptr_inc(wptr_r);
         end
         if (do_pop_s) begin
            rptr_r <= ptr_inc(rptr_r);
         end
         count_r <= count_next_s;
      end
   end

endmodule

// File: rtl/lsu_dmem_if.sv
// Load/store front-end between execute and one 32-bit data-RAM port.
// Request path is combinational; loads are tracked in a meta FIFO and their
// extended results are buffered in a response FIFO so the core can stall.
// Optional build macro: LSU_MISALIGN_TRAP_EN (trap misaligned/illegal accesses
// instead of silently aligning them).
module lsu_dmem_if
   import lsu_pkg::*;
#(
   parameter int ADDR_W    = 15,
   parameter int RSP_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rstf,
   input  logic              t_req_valid,
   output logic              t_req_ready,
   input  logic              t_req_we,
   input  logic [2:0]        t_req_funct3,
   input  logic [ADDR_W-1:0] t_req_addr,
   input  logic [31:0]       t_req_wdata,
   output logic              i_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [31:0]       i_rsp_data,
   output logic              i_mem_valid,
   input  logic              i_mem_ready,
   output logic              i_mem_we,
   output logic [ADDR_W-1:0] i_mem_addr,
   output logic [31:0]       i_mem_data,
   output logic [3:0]        i_mem_mask,
   input  logic              t_mrsp_valid,
   output logic              t_mrsp_ready,
   input  logic [31:0]       t_mrsp_data,
   output logic              o_misalign,
   output logic [ADDR_W-1:0] o_badaddr
);
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);

   logic [1:0]       size_s;
   logic [1:0]       off_s;
   logic             trap_s;
   logic             issue_ok_s;
   logic             load_issue_s;
   logic             meta_pop_s;
   logic             meta_empty_s;
   logic             rsp_empty_s;
   logic             rsp_pop_s;
   logic [CNT_W-1:0] meta_cnt_s;
   logic [CNT_W-1:0] rsp_cnt_s;
   logic [CNT_W-1:0] cnt_s;
   lsu_meta_t        meta_in_s;
   lsu_meta_t        meta_head_s;
   logic [31:0]      rsp_word_s;

   assign size_s = lsu_size(t_req_funct3);

   // Lane offset: halfwords drop addr[0], words drop both low bits
   always_comb begin
      off_s = t_req_addr[1:0];
      case (size_s)
         SZ_H:    off_s = {t_req_addr[1], 1'b0};
         SZ_W:    off_s = 2'b00;
         default: off_s = t_req_addr[1:0];
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap_s = lsu_trap(t_req_funct3, t_req_addr[1:0]);
`else
   assign trap_s = 1'b0;
`endif

   // Loads in flight plus buffered results; bounds the response FIFO
   assign cnt_s      = meta_cnt_s + rsp_cnt_s;
   assign issue_ok_s = t_req_we | (cnt_s < CNT_W'(RSP_DEPTH));

   // A trapping request is consumed without touching the RAM
   assign t_req_ready = trap_s ? 1'b1 : (i_mem_ready & issue_ok_s);
   assign i_mem_valid = t_req_valid & issue_ok_s & ~trap_s;
   assign i_mem_we    = t_req_we;
   assign i_mem_addr  = t_req_addr;
   assign i_mem_mask  = lsu_mask(size_s, off_s);
   assign i_mem_data  = lsu_wdata(size_s, t_req_wdata);

   assign t_mrsp_ready = 1'b1;

   assign load_issue_s  = i_mem_valid & i_mem_ready & ~t_req_we;
   assign meta_in_s.off = off_s;
   assign meta_in_s.f3  = t_req_funct3;

   // Read data with no matching load (e.g. in flight across reset) is dropped
   assign meta_pop_s = t_mrsp_valid & ~meta_empty_s;
   assign rsp_word_s = lsu_extend(t_mrsp_data, meta_head_s);

   assign i_rsp_valid = ~rsp_empty_s;
   assign rsp_pop_s   = i_rsp_valid & i_rsp_ready;

   lsu_fifo #(
      .WIDTH ($bits(lsu_meta_t)),
      .DEPTH (RSP_DEPTH)
   ) u_meta_fifo (
      .clk   (clk),
      .rstf  (rstf),
      .push  (load_issue_s),
      .wdata (meta_in_s),
      .pop   (meta_pop_s),
      .rdata (meta_head_s),
      .empty (meta_empty_s),
      .count (meta_cnt_s)
   );

   lsu_fifo #(
      .WIDTH (32),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk   (clk),
      .rstf  (rstf),
      .push  (meta_pop_s),
      .wdata (rsp_word_s),
      .pop   (rsp_pop_s),
      .rdata (i_rsp_data),
      .empty (rsp_empty_s),
      .count (rsp_cnt_s)
   );

`ifdef LSU_MISALIGN_TRAP_EN
   logic              misalign_r;
   logic [ADDR_W-1:0] badaddr_r;

   // One-cycle trap pulse and the faulting address of the last trap
   always_ff @(posedge clk) begin
      if (rstf) begin
         misalign_r <= 1'b0;
         badaddr_r  <= {ADDR_W{1'b0}};
      end else begin
         misalign_r <= t_req_valid & trap_s;
         if (t_req_valid & trap_s) begin
            badaddr_r <= t_req_addr;
         end
      end
   end

   assign o_misalign = misalign_r;
   assign o_badaddr  = badaddr_r;
`else
   assign o_misalign = 1'b0;
   assign o_badaddr  = {ADDR_W{1'b0}};
`endif

endmodule

// File: tb/tb_lsu_dmem_if.sv
// Directed bench for lsu_dmem_if: lane encoding, load extension, response
// buffering/backpressure, reset flush and the misaligned-access behaviour.
module tb_lsu_dmem_if;
   import lsu_pkg::*;

   localparam int ADDR_W = 15;

   logic              clk = 1'b0;
   logic              rstf;
   logic              t_req_valid;
   logic              t_req_ready;
   logic              t_req_we;
   logic [2:0]        t_req_funct3;
   logic [ADDR_W-1:0] t_req_addr;
   logic [31:0]       t_req_wdata;
   logic              i_rsp_valid;
   logic              i_rsp_ready;
   logic [31:0]       i_rsp_data;
   logic              i_mem_valid;
   logic              i_mem_ready;
   logic              i_mem_we;
   logic [ADDR_W-1:0] i_mem_addr;
   logic [31:0]       i_mem_data;
   logic [3:0]        i_mem_mask;
   logic              t_mrsp_valid;
   logic              t_mrsp_ready;
   logic [31:0]       t_mrsp_data;
   logic              o_misalign;
   logic [ADDR_W-1:0] o_badaddr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu_dmem_if #(.ADDR_W(ADDR_W), .RSP_DEPTH(2)) dut (
      .clk(clk), .rstf(rstf),
      .t_req_valid(t_req_valid), .t_req_ready(t_req_ready), .t_req_we(t_req_we),
      .t_req_funct3(t_req_funct3), .t_req_addr(t_req_addr), .t_req_wdata(t_req_wdata),
      .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
      .i_mem_valid(i_mem_valid), .i_mem_ready(i_mem_ready), .i_mem_we(i_mem_we),
      .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data), .i_mem_mask(i_mem_mask),
      .t_mrsp_valid(t_mrsp_valid), .t_mrsp_ready(t_mrsp_ready), .t_mrsp_data(t_mrsp_data),
      .o_misalign(o_misalign), .o_badaddr(o_badaddr)
   );

   task automatic set_req(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wd);
      @(negedge clk);
      t_req_valid  = 1'b1;
      t_req_we     = we;
      t_req_funct3 = f3;
      t_req_addr   = addr;
      t_req_wdata  = wd;
      #1;
   endtask

   task automatic end_req();
      @(posedge clk); #1;
      t_req_valid = 1'b0;
      #1;
   endtask

   // Issue edge for a pending load, then the RAM word one cycle later
   task automatic return_word(input logic [31:0] w);
      @(posedge clk); #1;
      t_req_valid  = 1'b0;
      t_mrsp_valid = 1'b1;
      t_mrsp_data  = w;
      @(posedge clk); #1;
      t_mrsp_valid = 1'b0;
      t_mrsp_data  = 32'h0;
      #1;
   endtask

   task automatic pop_rsp();
      @(negedge clk);
      i_rsp_ready = 1'b1;
      @(posedge clk); #1;
      i_rsp_ready = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rstf = 1'b1; t_req_valid = 1'b0; t_req_we = 1'b0; t_req_funct3 = 3'd0;
      t_req_addr = 15'h0; t_req_wdata = 32'h0; i_rsp_ready = 1'b0; i_mem_ready = 1'b1;
      t_mrsp_valid = 1'b0; t_mrsp_data = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (i_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b exp 0", i_rsp_valid); end
      checks++; if (i_rsp_data !== 32'h0) begin errors++; $display("FAIL rst_rsp_data: got %h exp 00000000", i_rsp_data); end
      checks++; if (o_misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b exp 0", o_misalign); end
      checks++; if (o_badaddr !== 15'h0) begin errors++; $display("FAIL rst_badaddr: got %h exp 0", o_badaddr); end
      checks++; if (t_mrsp_ready !== 1'b1) begin errors++; $display("FAIL rst_mrsp_ready: got %b exp 1", t_mrsp_ready); end
      t_req_valid = 1'b1; t_req_funct3 = 3'd2; t_req_addr = 15'h0004;
      #1;
      checks++; if (i_mem_valid !== 1'b1) begin errors++; $display("FAIL rst_comb_follow: got %b exp 1", i_mem_valid); end
      t_req_valid = 1'b0;
      @(negedge clk);
      rstf = 1'b0;
   endtask

   task automatic test_word();
      set_req(1'b1, 3'd2, 15'h0010, 32'hDEADBEEF);
      checks++; if (i_mem_valid !== 1'b1 || t_req_ready !== 1'b1) begin errors++; $display("FAIL sw_handshake: got valid=%b ready=%b exp 1/1", i_mem_valid, t_req_ready); end
      checks++; if (i_mem_we !== 1'b1 || i_mem_mask !== 4'hF) begin errors++; $display("FAIL sw_mask: got we=%b mask=%b exp 1/1111", i_mem_we, i_mem_mask); end
      checks++; if (i_mem_data !== 32'hDEADBEEF || i_mem_addr !== 15'h0010) begin errors++; $display("FAIL sw_data: got %h @%h exp deadbeef @0010", i_mem_data, i_mem_addr); end
      i_mem_ready = 1'b0; #1;
      checks++; if (t_req_ready !== 1'b0) begin errors++; $display("FAIL mem_not_ready: got %b exp 0", t_req_ready); end
      i_mem_ready = 1'b1; #1;
      end_req();
      set_req(1'b0, 3'd2, 15'h0010, 32'h0);
      checks++; if (i_mem_valid !== 1'b1 || i_mem_we !== 1'b0 || i_mem_mask !== 4'hF) begin errors++; $display("FAIL lw_req: got valid=%b we=%b mask=%b exp 1/0/1111", i_mem_valid, i_mem_we, i_mem_mask); end
      return_word(32'hDEADBEEF);
      checks++; if (i_rsp_valid !== 1'b1 || i_rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rsp: got v=%b %h exp 1 deadbeef", i_rsp_valid, i_rsp_data); end
      pop_rsp();
      checks++; if (i_rsp_valid !== 1'b0) begin errors++; $display("FAIL lw_pop: got %b exp 0", i_rsp_valid); end
   endtask

   task automatic test_byte();
      set_req(1'b1, 3'd0, 15'h0013, 32'h00000080);
      checks++; if (i_mem_mask !== 4'b1000 || i_mem_data !== 32'h80808080) begin errors++; $display("FAIL sb_lanes: got %b %h exp 1000 80808080", i_mem_mask, i_mem_data); end
      end_req();
      set_req(1'b0, 3'd0, 15'h0013, 32'h0);
      checks++; if (i_mem_mask !== 4'b1000) begin errors++; $display("FAIL lb_mask: got %b exp 1000", i_mem_mask); end
      return_word(32'h80123456);
      checks++; if (i_rsp_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext: got %h exp ffffff80", i_rsp_data); end
      pop_rsp();
      set_req(1'b0, 3'd4, 15'h0013, 32'h0);
      return_word(32'h80123456);
      checks++; if (i_rsp_data !== 32'h00000080) begin errors++; $display("FAIL lbu_zext: got %h exp 00000080", i_rsp_data); end
      pop_rsp();
      set_req(1'b0, 3'd0, 15'h0011, 32'h0);
      checks++; if (i_mem_mask !== 4'b0010) begin errors++; $display("FAIL lb1_mask: got %b exp 0010", i_mem_mask); end
      return_word(32'h80127F56);
      checks++; if (i_rsp_data !== 32'h0000007F) begin errors++; $display("FAIL lb_pos: got %h exp 0000007f", i_rsp_data); end
      pop_rsp();
   endtask

   task automatic test_half();
      set_req(1'b1, 3'd1, 15'h0022, 32'h00008001);
      checks++; if (i_mem_mask !== 4'b1100 || i_mem_data !== 32'h80018001) begin errors++; $display("FAIL sh_lanes: got %b %h exp 1100 80018001", i_mem_mask, i_mem_data); end
      end_req();
      set_req(1'b0, 3'd1, 15'h0022, 32'h0);
      checks++; if (i_mem_mask !== 4'b1100) begin errors++; $display("FAIL lh_mask: got %b exp 1100", i_mem_mask); end
      return_word(32'h80011234);
      checks++; if (i_rsp_data !== 32'hFFFF8001) begin errors++; $display("FAIL lh_sext: got %h exp ffff8001", i_rsp_data); end
      pop_rsp();
      set_req(1'b0, 3'd5, 15'h0022, 32'h0);
      return_word(32'h80011234);
      checks++; if (i_rsp_data !== 32'h00008001) begin errors++; $display("FAIL lhu_zext: got %h exp 00008001", i_rsp_data); end
      pop_rsp();
      set_req(1'b1, 3'd1, 15'h0020, 32'h0000A55A);
      checks++; if (i_mem_mask !== 4'b0011 || i_mem_data !== 32'hA55AA55A) begin errors++; $display("FAIL sh0_lanes: got %b %h exp 0011 a55aa55a", i_mem_mask, i_mem_data); end
      end_req();
   endtask

   task automatic test_back_to_back();
      i_rsp_ready = 1'b0;
      set_req(1'b0, 3'd2, 15'h0040, 32'h0);
      checks++; if (t_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ld1_ready: got %b exp 1", t_req_ready); end
      @(posedge clk); #1;
      t_req_addr = 15'h0044; t_mrsp_valid = 1'b1; t_mrsp_data = 32'hAAAA0001;
      #1;
      checks++; if (t_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ld2_ready: got %b exp 1", t_req_ready); end
      @(posedge clk); #1;
      t_req_addr = 15'h0048; t_mrsp_data = 32'hBBBB0002;
      #1;
      checks++; if (t_req_ready !== 1'b0 || i_mem_valid !== 1'b0) begin errors++; $display("FAIL b2b_stall: got ready=%b valid=%b exp 0/0", t_req_ready, i_mem_valid); end
      @(posedge clk); #1;
      t_mrsp_valid = 1'b0; t_req_we = 1'b1; t_req_wdata = 32'h00000055; t_req_addr = 15'h0080;
      #1;
      checks++; if (t_req_ready !== 1'b1 || i_mem_valid !== 1'b1) begin errors++; $display("FAIL b2b_store_in_stall: got ready=%b valid=%b exp 1/1", t_req_ready, i_mem_valid); end
      @(posedge clk); #1;
      t_req_we = 1'b0; t_req_addr = 15'h0048;
      #1;
      checks++; if (t_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_still_full: got %b exp 0", t_req_ready); end
      checks++; if (i_rsp_valid !== 1'b1 || i_rsp_data !== 32'hAAAA0001) begin errors++; $display("FAIL b2b_first: got v=%b %h exp 1 aaaa0001", i_rsp_valid, i_rsp_data); end
      i_rsp_ready = 1'b1;
      #1;
      checks++; if (t_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_pop_same_cycle: got %b exp 0", t_req_ready); end
      @(posedge clk); #1;
      i_rsp_ready = 1'b0;
      #1;
      checks++; if (t_req_ready !== 1'b1 || i_rsp_data !== 32'hBBBB0002) begin errors++; $display("FAIL b2b_release: got ready=%b %h exp 1 bbbb0002", t_req_ready, i_rsp_data); end
      @(posedge clk); #1;
      t_req_valid = 1'b0; t_mrsp_valid = 1'b1; t_mrsp_data = 32'hCCCC0003;
      @(posedge clk); #1;
      t_mrsp_valid = 1'b0;
      #1;
      checks++; if (i_rsp_data !== 32'hBBBB0002) begin errors++; $display("FAIL b2b_head_hold: got %h exp bbbb0002", i_rsp_data); end
      pop_rsp();
      checks++; if (i_rsp_valid !== 1'b1 || i_rsp_data !== 32'hCCCC0003) begin errors++; $display("FAIL b2b_third: got v=%b %h exp 1 cccc0003", i_rsp_valid, i_rsp_data); end
      pop_rsp();
      checks++; if (i_rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b exp 0", i_rsp_valid); end
   endtask

   task automatic test_reset_flush();
      i_rsp_ready = 1'b0;
      set_req(1'b0, 3'd2, 15'h0100, 32'h0);
      @(posedge clk); #1;
      t_req_addr = 15'h0104; t_mrsp_valid = 1'b1; t_mrsp_data = 32'h00000001;
      @(posedge clk); #1;
      t_req_valid = 1'b0; t_mrsp_data = 32'h00000002;
      @(posedge clk); #1;
      t_mrsp_valid = 1'b0;
      #1;
      checks++; if (i_rsp_valid !== 1'b1 || i_rsp_data !== 32'h00000001) begin errors++; $display("FAIL flush_pre: got v=%b %h exp 1 00000001", i_rsp_valid, i_rsp_data); end
      t_req_valid = 1'b1; t_req_addr = 15'h0108; rstf = 1'b1;
      #1;
      checks++; if (t_req_ready !== 1'b0) begin errors++; $display("FAIL flush_rst_cnt_block: got %b exp 0", t_req_ready); end
      @(posedge clk); #1;
      checks++; if (t_req_ready !== 1'b1 || i_mem_valid !== 1'b1) begin errors++; $display("FAIL flush_rst_follow: got ready=%b valid=%b exp 1/1", t_req_ready, i_mem_valid); end
      checks++; if (i_rsp_valid !== 1'b0 || i_rsp_data !== 32'h0) begin errors++; $display("FAIL flush_rsp_cleared: got v=%b %h exp 0 00000000", i_rsp_valid, i_rsp_data); end
      t_req_valid = 1'b0;
      @(posedge clk); #1;
      rstf = 1'b0; t_mrsp_valid = 1'b1; t_mrsp_data = 32'h12345678;
      @(posedge clk); #1;
      t_mrsp_valid = 1'b0;
      #1;
      checks++; if (i_rsp_valid !== 1'b0 || i_rsp_data !== 32'h0) begin errors++; $display("FAIL flush_late_drop: got v=%b %h exp 0 00000000", i_rsp_valid, i_rsp_data); end
      set_req(1'b0, 3'd2, 15'h010C, 32'h0);
      checks++; if (t_req_ready !== 1'b1) begin errors++; $display("FAIL flush_resume_ready: got %b exp 1", t_req_ready); end
      return_word(32'hCAFEF00D);
      checks++; if (i_rsp_valid !== 1'b1 || i_rsp_data !== 32'hCAFEF00D) begin errors++; $display("FAIL flush_resume_rsp: got v=%b %h exp 1 cafef00d", i_rsp_valid, i_rsp_data); end
      pop_rsp();
   endtask

`ifdef LSU_MISALIGN_TRAP_EN
   task automatic test_misalign();
      set_req(1'b0, 3'd2, 15'h0011, 32'h0);
      checks++; if (t_req_ready !== 1'b1 || i_mem_valid !== 1'b0) begin errors++; $display("FAIL trap_lw_req: got ready=%b valid=%b exp 1/0", t_req_ready, i_mem_valid); end
      @(posedge clk); #1;
      t_req_valid = 1'b0;
      #1;
      checks++; if (o_misalign !== 1'b1 || o_badaddr !== 15'h0011) begin errors++; $display("FAIL trap_pulse: got %b @%h exp 1 @0011", o_misalign, o_badaddr); end
      @(posedge clk); #1;
      checks++; if (o_misalign !== 1'b0 || o_badaddr !== 15'h0011) begin errors++; $display("FAIL trap_pulse_end: got %b @%h exp 0 @0011", o_misalign, o_badaddr); end
      checks++; if (i_rsp_valid !== 1'b0) begin errors++; $display("FAIL trap_no_rsp: got %b exp 0", i_rsp_valid); end
      set_req(1'b0, 3'd3, 15'h0040, 32'h0);
      checks++; if (i_mem_valid !== 1'b0) begin errors++; $display("FAIL trap_f3_req: got %b exp 0", i_mem_valid); end
      end_req();
      checks++; if (o_misalign !== 1'b1 || o_badaddr !== 15'h0040) begin errors++; $display("FAIL trap_f3_pulse: got %b @%h exp 1 @0040", o_misalign, o_badaddr); end
      set_req(1'b0, 3'd1, 15'h0022, 32'h0);
      checks++; if (i_mem_valid !== 1'b1 || i_mem_mask !== 4'b1100) begin errors++; $display("FAIL trap_legal_lh: got %b %b exp 1 1100", i_mem_valid, i_mem_mask); end
      return_word(32'h7FFF0000);
      checks++; if (i_rsp_data !== 32'h00007FFF || o_misalign !== 1'b0) begin errors++; $display("FAIL trap_legal_rsp: got %h mis=%b exp 00007fff 0", i_rsp_data, o_misalign); end
      pop_rsp();
   endtask
`else
   task automatic test_misalign();
      set_req(1'b0, 3'd2, 15'h0011, 32'h0);
      checks++; if (i_mem_valid !== 1'b1 || i_mem_addr[ADDR_W-1:2] !== 13'h0004 || i_mem_mask !== 4'hF) begin errors++; $display("FAIL noalign_lw_req: got v=%b addr=%h mask=%b exp 1 word 0010 1111", i_mem_valid, i_mem_addr, i_mem_mask); end
      return_word(32'h11223344);
      checks++; if (i_rsp_data !== 32'h11223344 || o_misalign !== 1'b0) begin errors++; $display("FAIL noalign_lw_rsp: got %h mis=%b exp 11223344 0", i_rsp_data, o_misalign); end
      pop_rsp();
      set_req(1'b0, 3'd1, 15'h0023, 32'h0);
      checks++; if (i_mem_mask !== 4'b1100) begin errors++; $display("FAIL noalign_lh_mask: got %b exp 1100", i_mem_mask); end
      return_word(32'hABCD0000);
      checks++; if (i_rsp_data !== 32'hFFFFABCD) begin errors++; $display("FAIL noalign_lh_rsp: got %h exp ffffabcd", i_rsp_data); end
      pop_rsp();
      set_req(1'b0, 3'd3, 15'h0031, 32'h0);
      checks++; if (i_mem_valid !== 1'b1 || i_mem_mask !== 4'hF) begin errors++; $display("FAIL illegal_f3_mask: got %b %b exp 1 1111", i_mem_valid, i_mem_mask); end
      return_word(32'h0BADF00D);
      checks++; if (i_rsp_data !== 32'h0BADF00D) begin errors++; $display("FAIL illegal_f3_rsp: got %h exp 0badf00d", i_rsp_data); end
      pop_rsp();
      checks++; if (o_badaddr !== 15'h0) begin errors++; $display("FAIL noalign_badaddr: got %h exp 0", o_badaddr); end
   endtask
`endif

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_back_to_back();
      test_reset_flush();
      test_misalign();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
